alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised successor to the combinational ALU control decoder: decodes ALUOp/func,
//  executes single-cycle ops, and sequences iterative MULT/DIV into HI/LO registers.
//  Sits in EX stage; valid/ready handshake both sides lets the pipeline stall on multi-cycle ops.
// PARAMETERS
//  DATA_W   32  operand/result width (>=8, even)
//  CNT_W    $clog2(DATA_W)+1  iteration counter width (derived, localparam)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       request present
//  in_ready   out  1       unit accepts request this cycle
//  ALUOp      in   2       00 ADD, 01 SUB, 10 R-type (use func), 11 SLT
//  func       in   6       MIPS funct field (valid when ALUOp==10)
//  op_a       in   DATA_W  operand rs
//  op_b       in   DATA_W  operand rt
//  out_valid  out  1       result valid; held until out_ready
//  out_ready  in   1       consumer takes result
//  result     out  DATA_W  ALU result / LO after MULT*/DIV*
//  zero       out  1       result==0
//  illegal    out  1       qualified by out_valid: unsupported func/op
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, result=0, zero=0 (not the result==0 identity;
//    zero is a registered flag, cleared), illegal=0, HI=LO=0, counter=0.
//  - Transfer on in_valid&in_ready; in_ready = (state==IDLE)&&(!out_valid||out_ready).
//  - R-type funcs: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed),
//    011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO.
//    Any other func -> result 0, illegal=1, latency 1.
//  - Single-cycle ops (incl. MFHI/MFLO): result registered, out_valid 1 cycle after accept.
//    ADD/SUB wrap modulo 2^DATA_W, no overflow trap. SLT -> {0..0,a<b signed}.
//  - FSM: IDLE -> MUL | DIV on accept of MULT*/DIV*; MUL/DIV run DATA_W iterations
//    (one bit per cycle), then FIX (sign correction, HI/LO write) -> DONE; DONE asserts
//    out_valid, returns to IDLE on out_ready. Latency accept->out_valid = DATA_W+2.
//  - MULT/MULTU: {HI,LO} = 2*DATA_W-bit product; signed uses magnitudes + final negate.
//  - DIV/DIVU: restoring division; LO=quotient, HI=remainder; remainder sign = dividend sign.
//    Divide by zero: LO=all ones, HI=op_a, illegal=0. Signed MIN/-1: LO=MIN, HI=0.
//  - result for MULT*/DIV* = new LO; zero computed on result.
//  - out_valid&!out_ready: result/zero/illegal stable; no new accept.
//  - rst mid-sequence aborts, HI/LO cleared; no partial write. HI/LO update only in FIX.
// CONFIGURATION
//  ALU_EXEC_DIVIDER_EN defined: DIV/DIVU executed as above.
//  Undefined: divider logic absent; DIV/DIVU treated as illegal (latency 1, HI/LO unchanged).
// STRUCTURE
//  Shared package alu_pkg: ALUOp encodings, func codes, internal 4-bit ALUctrl codes
//  (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111), FSM state enum.
//  Sub-module alu_muldiv_seq: shift/add-subtract datapath + counter, start/done handshake;
//  top keeps decode, single-cycle ALU, FSM, output register.
// TESTING
//  1 ALUOp=10 func=100010 a=5 b=7 -> next cycle result=FFFFFFFE, zero=0, illegal=0.
//  2 MULT a=FFFFFFFD(-3) b=7 -> after 34 cycles result=FFFFFFEB; MFHI -> FFFFFFFF.
//  3 DIV a=FFFFFFF9(-7) b=2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIV a=9 b=0 -> LO=FFFFFFFF, HI=9.
//  4 out_ready=0 for 5 cycles after ADD -> result held, in_ready=0; then accepts next op.
//  5 rst at iteration 10 of MULTU -> next cycle IDLE, out_valid=0, MFLO returns 0.
//  6 func=111111 -> illegal=1, result=0; without ALU_EXEC_DIVIDER_EN DIVU -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU execution unit.
//   - ALUOp encodings and MIPS funct codes
//   - internal 4-bit ALU control codes
//   - FSM state enum and operation classes
//   - decode_op(): maps ALUOp/func to an operation class and ALU control code
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;

  typedef enum logic [3:0] {
    ALUCTRL_AND = 4'b0000,
    ALUCTRL_OR  = 4'b0001,
    ALUCTRL_ADD = 4'b0010,
    ALUCTRL_SUB = 4'b0110,
    ALUCTRL_SLT = 4'b0111
  } aluctrl_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MFHI,
    CLS_MFLO,
    CLS_MUL,
    CLS_DIV,
    CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    op_class_e op_class;
    aluctrl_e  ctrl;
    logic      is_signed;
  } decode_t;

  // div_en = 0 folds DIV/DIVU into the illegal class so they complete in one cycle.
  function automatic decode_t decode_op(input logic [1:0] aluop,
                                        input logic [5:0] func,
                                        input logic       div_en);
    decode_t d;
    d.op_class  = CLS_ALU;
    d.ctrl      = ALUCTRL_ADD;
    d.is_signed = 1'b0;
    case (aluop)
      ALUOP_ADD: d.ctrl = ALUCTRL_ADD;
      ALUOP_SUB: d.ctrl = ALUCTRL_SUB;
      ALUOP_SLT: d.ctrl = ALUCTRL_SLT;
      default: begin
        case (func)
          FUNC_ADD:   d.ctrl = ALUCTRL_ADD;
          FUNC_SUB:   d.ctrl = ALUCTRL_SUB;
          FUNC_AND:   d.ctrl = ALUCTRL_AND;
          FUNC_OR:    d.ctrl = ALUCTRL_OR;
          FUNC_SLT:   d.ctrl = ALUCTRL_SLT;
          FUNC_MFHI:  d.op_class = CLS_MFHI;
          FUNC_MFLO:  d.op_class = CLS_MFLO;
          FUNC_MULT: begin
            d.op_class  = CLS_MUL;
            d.is_signed = 1'b1;
          end
          FUNC_MULTU: d.op_class = CLS_MUL;
          FUNC_DIV: begin
            d.op_class  = div_en ? CLS_DIV : CLS_ILLEGAL;
            d.is_signed = 1'b1;
          end
          FUNC_DIVU:  d.op_class = div_en ? CLS_DIV : CLS_ILLEGAL;
          default:    d.op_class = CLS_ILLEGAL;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply / divide datapath, one bit per cycle.
//   clk, rst        : clock, synchronous active-high reset
//   start           : load operands and begin DATA_W iterations
//   is_div          : (only with ALU_EXEC_DIVIDER_EN) divide instead of multiply
//   is_signed       : operands are two's complement
//   op_a, op_b      : dividend/multiplicand, divisor/multiplier
//   done            : high during the cycle that performs the last iteration
//   hi, lo          : sign-corrected result, valid once iterations are complete
// Macro ALU_EXEC_DIVIDER_EN includes the restoring divider; without it only
// multiplication is built.
module alu_muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef ALU_EXEC_DIVIDER_EN
  input  logic              is_div,
`endif
  input  logic              is_signed,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [CNT_W-1:0]    cnt_reg;
  // acc: upper product half / partial remainder; mq: multiplier / quotient
  logic [DATA_W-1:0]   acc_reg;
  logic [DATA_W-1:0]   mq_reg;
  logic [DATA_W-1:0]   m_reg;
  logic                neg_q_reg;   // product or quotient must be negated
`ifdef ALU_EXEC_DIVIDER_EN
  logic                div_reg;
  logic                neg_r_reg;   // remainder takes the dividend's sign
  logic                bzero_reg;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W-1:0]   div_diff;
  logic                div_fits;
`endif

  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_fix;

  always_comb begin
    a_neg   = is_signed & op_a[DATA_W-1];
    b_neg   = is_signed & op_b[DATA_W-1];
    a_mag   = a_neg ? -op_a : op_a;
    b_mag   = b_neg ? -op_b : op_b;
    mul_sum = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, m_reg} : '0);
`ifdef ALU_EXEC_DIVIDER_EN
    div_shift = {acc_reg, mq_reg[DATA_W-1]};
    div_fits  = (div_shift >= {1'b0, m_reg});
    // Only used when div_fits, where the true difference is below m_reg.
    div_diff  = div_shift[DATA_W-1:0] - m_reg;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mq_reg    <= '0;
      m_reg     <= '0;
      neg_q_reg <= 1'b0;
`ifdef ALU_EXEC_DIVIDER_EN
      div_reg   <= 1'b0;
      neg_r_reg <= 1'b0;
      bzero_reg <= 1'b0;
`endif
    end else if (start) begin
      cnt_reg   <= CNT_W'(DATA_W);
      acc_reg   <= '0;
      mq_reg    <= a_mag;
      m_reg     <= b_mag;
      neg_q_reg <= a_neg ^ b_neg;
`ifdef ALU_EXEC_DIVIDER_EN
      div_reg   <= is_div;
      neg_r_reg <= a_neg;
      bzero_reg <= (op_b == '0);
`endif
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
`ifdef ALU_EXEC_DIVIDER_EN
      if (div_reg) begin
        // Restoring step: shift next dividend bit in, subtract if it fits.
        if (div_fits) begin
          acc_reg <= div_diff;
          mq_reg  <= {mq_reg[DATA_W-2:0], 1'b1};
        end else begin
          acc_reg <= div_shift[DATA_W-1:0];
          mq_reg  <= {mq_reg[DATA_W-2:0], 1'b0};
        end
      end else begin
        acc_reg <= mul_sum[DATA_W:1];
        mq_reg  <= {mul_sum[0], mq_reg[DATA_W-1:1]};
      end
`else
      // Shift-add: {carry,acc,mq} shifts right one bit per iteration.
      acc_reg <= mul_sum[DATA_W:1];
      mq_reg  <= {mul_sum[0], mq_reg[DATA_W-1:1]};
`endif
    end
  end

  always_comb begin
    prod     = {acc_reg, mq_reg};
    prod_fix = neg_q_reg ? -prod : prod;
    hi       = prod_fix[2*DATA_W-1:DATA_W];
    lo       = prod_fix[DATA_W-1:0];
`ifdef ALU_EXEC_DIVIDER_EN
    if (div_reg) begin
      lo = neg_q_reg ? -mq_reg : mq_reg;
      hi = neg_r_reg ? -acc_reg : acc_reg;
      // The sign-corrected remainder already equals op_a here; only the
      // quotient needs forcing to all ones.
      if (bzero_reg) lo = '1;
    end
`endif
  end

  assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU execution unit: decodes ALUOp/func, executes single-cycle ops,
// and sequences iterative MULT/DIV into HI/LO.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake
//   ALUOp, func         : operation select (func used when ALUOp == 2'b10)
//   op_a, op_b          : operands rs / rt
//   out_valid/out_ready : result handshake; result held while stalled
//   result, zero        : registered result and result==0 flag
//   illegal             : unsupported operation (qualified by out_valid)
// Macro ALU_EXEC_DIVIDER_EN enables DIV/DIVU; otherwise they report illegal.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

`ifdef ALU_EXEC_DIVIDER_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  state_e            state_reg, state_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              zero_reg, zero_next;
  logic              illegal_reg, illegal_next;
  logic [DATA_W-1:0] hi_reg, hi_next;
  logic [DATA_W-1:0] lo_reg, lo_next;

  decode_t           dec;
  logic              accept;
  logic              seq_start;
  logic              seq_done;
  logic [DATA_W-1:0] seq_hi;
  logic [DATA_W-1:0] seq_lo;
  logic [DATA_W-1:0] alu_res;

  assign dec       = decode_op(ALUOp, func, DIV_EN);
  assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign seq_start = accept && ((dec.op_class == CLS_MUL) || (dec.op_class == CLS_DIV));

  alu_muldiv_seq #(
    .DATA_W(DATA_W)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start),
`ifdef ALU_EXEC_DIVIDER_EN
    .is_div   (dec.op_class == CLS_DIV),
`endif
    .is_signed(dec.is_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .done     (seq_done),
    .hi       (seq_hi),
    .lo       (seq_lo)
  );

  // Single-cycle result path; illegal ops fall through to zero.
  always_comb begin
    alu_res = '0;
    case (dec.op_class)
      CLS_ALU: begin
        case (dec.ctrl)
          ALUCTRL_AND: alu_res = op_a & op_b;
          ALUCTRL_OR:  alu_res = op_a | op_b;
          ALUCTRL_ADD: alu_res = op_a + op_b;
          ALUCTRL_SUB: alu_res = op_a - op_b;
          ALUCTRL_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default:     alu_res = '0;
        endcase
      end
      CLS_MFHI: alu_res = hi_reg;
      CLS_MFLO: alu_res = lo_reg;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    result_next    = result_reg;
    zero_next      = zero_reg;
    illegal_next   = illegal_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (out_valid_reg && out_ready) out_valid_next = 1'b0;
        if (accept) begin
          case (dec.op_class)
            CLS_MUL: state_next = ST_MUL;
            CLS_DIV: state_next = ST_DIV;
            default: begin
              result_next    = alu_res;
              zero_next      = (alu_res == '0);
              illegal_next   = (dec.op_class == CLS_ILLEGAL);
              out_valid_next = 1'b1;
            end
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (seq_done) state_next = ST_FIX;
      end
      ST_FIX: begin
        // HI/LO change only here, so an abort by rst never leaves a partial write.
        hi_next        = seq_hi;
        lo_next        = seq_lo;
        result_next    = seq_lo;
        zero_next      = (seq_lo == '0);
        illegal_next   = 1'b0;
        out_valid_next = 1'b1;
        state_next     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      zero_reg      <= zero_next;
      illegal_reg   <= illegal_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are computed by a
// behavioural model when an op is issued and compared when the DUT delivers.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   ALUOp;
  logic [5:0]   func;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUOp    (ALUOp),
    .func     (func),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           n_txn = 0;
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of the architectural behaviour, including HI/LO.
  task automatic model_op(input logic [1:0] aop, input logic [5:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output exp_t e, output bit multi);
    longint       sa, sb;
    logic [63:0]  p;
    int           ia, ib;
    e.res = '0; e.ill = 1'b0; multi = 1'b0;
    case (aop)
      2'b00: e.res = a + b;
      2'b01: e.res = a - b;
      2'b11: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        case (fn)
          6'b100000: e.res = a + b;
          6'b100010: e.res = a - b;
          6'b100100: e.res = a & b;
          6'b100101: e.res = a | b;
          6'b101010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'b010000: e.res = m_hi;
          6'b010010: e.res = m_lo;
          6'b011000: begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; multi = 1'b1;
          end
          6'b011001: begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; multi = 1'b1;
          end
`ifdef ALU_EXEC_DIVIDER_EN
          6'b011010, 6'b011011: begin
            multi = 1'b1;
            if (b == '0) begin
              m_lo = '1; m_hi = a;
            end else if (fn == 6'b011011) begin
              m_lo = a / b; m_hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              m_lo = a; m_hi = '0;
            end else begin
              ia = a; ib = b;
              m_lo = ia / ib; m_hi = ia % ib;
            end
            e.res = m_lo;
          end
`endif
          default: e.ill = 1'b1;
        endcase
      end
    endcase
    e.zero = (e.res == '0);
  endtask

  // Present a request until accepted; returns the cycle count after the accept edge.
  task automatic issue(input logic [1:0] aop, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output int acc_cyc, output bit ok);
    @(posedge clk); #1;
    ALUOp = aop; func = fn; op_a = a; op_b = b; in_valid = 1'b1;
    ok = 1'b0; acc_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        ok       = 1'b1;
        break;
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      chk("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic do_op(input logic [1:0] aop, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   multi, ok, seen;
    int   acc_cyc;
    model_op(aop, fn, a, b, e, multi);
    sb_q.push_back(e);
    issue(aop, fn, a, b, acc_cyc, ok);
    if (!ok) return;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("latency", 64'(cyc - acc_cyc + 1), multi ? 64'(W + 2) : 64'd1);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: a result transfers at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_txn++;
        $display("txn %0d: result=%h zero=%0b illegal=%0b (exp %h %0b %0b)",
                 n_txn, result, zero, illegal, e.res, e.zero, e.ill);
        chk("result", 64'(result), 64'(e.res));
        chk("zero", 64'(zero), 64'(e.zero));
        chk("illegal", 64'(illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    int  acc_cyc;
    bit  ok;
    logic [W-1:0] ra, rb;
    logic [5:0]   rfuncs [5];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = 2'b00; func = 6'd0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single-cycle ops, wrap and sign boundaries
    do_op(2'b10, 6'b100010, 32'd5, 32'd7);
    do_op(2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1);
    do_op(2'b01, 6'd0, 32'd3, 32'd3);
    do_op(2'b01, 6'd0, 32'd0, 32'd1);
    do_op(2'b11, 6'd0, 32'hFFFF_FFFF, 32'd1);
    do_op(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF);
    do_op(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
    do_op(2'b10, 6'b100101, 32'hF0F0_1234, 32'h0FF0_FF00);
    do_op(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1);

    // Multiply
    do_op(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);
    do_op(2'b10, 6'b010010, 32'd0, 32'd0);
    do_op(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);
    do_op(2'b10, 6'b011000, 32'h8000_0000, 32'h8000_0000);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);

    // Divide (illegal in a build without the divider)
    do_op(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);
    do_op(2'b10, 6'b011010, 32'd9, 32'd0);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);
    do_op(2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);
    do_op(2'b10, 6'b011011, 32'd100, 32'd7);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);
    do_op(2'b10, 6'b011010, 32'd100, 32'hFFFF_FFF9);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);

    // Unsupported func
    do_op(2'b10, 6'b111111, 32'd1, 32'd2);

    // Random single-cycle and multiply ops
    rfuncs[0] = 6'b100000; rfuncs[1] = 6'b100010; rfuncs[2] = 6'b100100;
    rfuncs[3] = 6'b101010; rfuncs[4] = 6'b011000;
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom;
      do_op(2'($urandom_range(0, 3)), rfuncs[$urandom_range(0, 4)], ra, rb);
    end
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);

    // Output stall: result held, no accept, even with a new request pending
    @(posedge clk); #1 out_ready = 1'b0;
    do_op(2'b00, 6'd0, 32'd20, 32'd22);
    @(posedge clk); #1;
    ALUOp = 2'b01; func = 6'd0; op_a = 32'd1; op_b = 32'd100; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_result", 64'(result), 64'd42);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    do_op(2'b01, 6'd0, 32'd1, 32'd100);

    // Reset during the 10th MULTU iteration
    issue(2'b10, 6'b011001, 32'h1234_5678, 32'h0000_9ABC, acc_cyc, ok);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_result", 64'(result), 64'd0);
    do_op(2'b10, 6'b010010, 32'd0, 32'd0);
    do_op(2'b10, 6'b010000, 32'd0, 32'd0);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
